// File: rtl/raycast_pkg.sv
// Shared geometry, field widths and write-FSM state for the wall column buffer.
package raycast_pkg;
    localparam int H_RES     = 640;
    localparam int V_RES     = 480;
    localparam int COL_SHIFT = 2;
    localparam int NUM_COLS  = H_RES >> COL_SHIFT;

    localparam int PIX_W    = 10;
    localparam int COL_W    = 8;
    localparam int HEIGHT_W = 9;
    localparam int COLOR_W  = 12;

    typedef struct packed {
        logic [HEIGHT_W-1:0] height;
        logic [COLOR_W-1:0]  color;
    } col_entry_t;

    typedef enum logic [1:0] {FILL, WAIT_SWAP, SWAP} wcb_state_t;
endpackage

// File: rtl/wall_column_buffer_if.sv
// Raycaster-side write bus: per-column entries plus the frame hand-off pulses.
interface wall_column_buffer_if;
    import raycast_pkg::*;

    logic                wr_valid;
    logic                wr_ready;
    logic [COL_W-1:0]    wr_col;
    logic [HEIGHT_W-1:0] wr_height;
    logic [COLOR_W-1:0]  wr_color;
    logic                frame_done;
    logic                frame_req;
    logic                wr_err;

    modport master (
        output wr_valid, wr_col, wr_height, wr_color, frame_done,
        input  wr_ready, frame_req, wr_err
    );

    modport slave (
        input  wr_valid, wr_col, wr_height, wr_color, frame_done,
        output wr_ready, frame_req, wr_err
    );
endinterface

// File: rtl/column_ram.sv
// Two banks of column entries: one write port, one registered read port.
module column_ram
    import raycast_pkg::*;
(
    input  logic             clk,
    input  logic             we,
    input  logic             wr_bank,
    input  logic [COL_W-1:0] wr_col,
    input  col_entry_t       wr_data,
    input  logic             re,
    input  logic             rd_bank,
    input  logic [COL_W-1:0] rd_col,
    output col_entry_t       rd_data
);
    // Bank is the outer index, acting as the address MSB.
    col_entry_t mem [2][NUM_COLS];

    always_ff @(posedge clk) begin
        if (we)
            mem[wr_bank][wr_col] <= wr_data;
        if (re)
            rd_data <= mem[rd_bank][rd_col];
    end
endmodule

// File: rtl/wall_column_buffer.sv
// Double-buffered wall-slice store; banks flip only at the start of vertical blank.
module wall_column_buffer
    import raycast_pkg::*;
(
    input  logic                 clk,
    input  logic                 RST,
    wall_column_buffer_if.slave  wr,
    input  logic                 p_tick,
    input  logic                 video_on,
    input  logic [PIX_W-1:0]     pixel_x,
    input  logic [PIX_W-1:0]     pixel_y,
    output logic                 graph_on,
    output logic [3:0]           graph_red,
    output logic [3:0]           graph_green,
    output logic [3:0]           graph_blue
);
    localparam logic [PIX_W-1:0] MID   = PIX_W'(V_RES / 2);
    localparam logic [PIX_W-1:0] VMAX  = PIX_W'(V_RES);
    localparam logic [PIX_W-1:0] NCOLS = PIX_W'(NUM_COLS);

    wcb_state_t state_q, state_d;
    logic       armed_q, bank_sel_q, front_valid_q, wr_err_q;
    logic       ready_c, req_c;

    wire swap_pt = p_tick && (pixel_y == VMAX) && (pixel_x == '0);
    wire accept  = wr.wr_valid && ready_c;
    wire wcol_ok = {2'b00, wr.wr_col} < NCOLS;

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) state_q <= FILL;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL:      if (wr.frame_done) state_d = WAIT_SWAP;
            WAIT_SWAP: if (swap_pt)       state_d = SWAP;
            SWAP:                         state_d = FILL;
            default:                      state_d = FILL;
        endcase
    end

    always_comb begin
        ready_c = 1'b0;
        req_c   = 1'b0;
        case (state_q)
            FILL:    ready_c = armed_q;
            SWAP:    req_c   = 1'b1;
            default: ;
        endcase
    end

    // armed_q keeps wr_ready low for the first cycle out of reset.
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            armed_q       <= 1'b0;
            bank_sel_q    <= 1'b0;
            front_valid_q <= 1'b0;
            wr_err_q      <= 1'b0;
        end else begin
            armed_q <= 1'b1;
            if (state_q == SWAP) begin
                bank_sel_q    <= ~bank_sel_q;
                front_valid_q <= 1'b1;
            end
            if (accept && !wcol_ok)
                wr_err_q <= 1'b1;
        end
    end

    assign wr.wr_ready  = ready_c;
    assign wr.frame_req = req_c;
    assign wr.wr_err    = wr_err_q;

    // Pixel stage 1: registered front-bank read on p_tick.
    logic [PIX_W-1:0] px_shift;
    logic             pcol_ok;
    col_entry_t       rd_ent;
    logic             s1_vld, s1_on;
    logic [PIX_W-1:0] s1_y;

    assign px_shift = pixel_x >> COL_SHIFT;
    assign pcol_ok  = px_shift < NCOLS;

    column_ram u_ram (
        .clk     (clk),
        .we      (accept && wcol_ok),
        .wr_bank (~bank_sel_q),
        .wr_col  (wr.wr_col),
        .wr_data ({wr.wr_height, wr.wr_color}),
        .re      (p_tick),
        .rd_bank (bank_sel_q),
        .rd_col  (pcol_ok ? px_shift[COL_W-1:0] : '0),
        .rd_data (rd_ent)
    );

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            s1_vld <= 1'b0;
            s1_on  <= 1'b0;
            s1_y   <= '0;
        end else begin
            s1_vld <= p_tick;
            if (p_tick) begin
                s1_on <= video_on && pcol_ok && front_valid_q;
                s1_y  <= pixel_y;
            end
        end
    end

    // Pixel stage 2: vertical extent compare, top saturates at 0 and bottom at V_RES.
    logic [PIX_W-1:0] half, top, bot_raw, bot;
    logic             wall;

    always_comb begin
        half    = PIX_W'(rd_ent.height >> 1);
        top     = (half >= MID) ? '0 : MID - half;
        bot_raw = MID + half;
        bot     = (bot_raw > VMAX) ? VMAX : bot_raw;
        wall    = s1_on && (s1_y >= top) && (s1_y < bot);
    end

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            graph_on    <= 1'b0;
            graph_red   <= '0;
            graph_green <= '0;
            graph_blue  <= '0;
        end else if (s1_vld) begin
            graph_on    <= wall;
            graph_red   <= wall ? rd_ent.color[11:8] : 4'h0;
            graph_green <= wall ? rd_ent.color[7:4]  : 4'h0;
            graph_blue  <= wall ? rd_ent.color[3:0]  : 4'h0;
        end
    end
endmodule

// File: tb/tb_wall_column_buffer.sv
// Directed bench: column writes, bank swap timing and pixel-path geometry.
module tb_wall_column_buffer;
    import raycast_pkg::*;

    logic       clk = 1'b0;
    logic       RST = 1'b0;
    logic       p_tick = 1'b0, video_on = 1'b0;
    logic [9:0] pixel_x = '0, pixel_y = '0;
    logic       graph_on;
    logic [3:0] graph_red, graph_green, graph_blue;

    wall_column_buffer_if wi();

    wall_column_buffer dut (
        .clk(clk), .RST(RST), .wr(wi.slave),
        .p_tick(p_tick), .video_on(video_on),
        .pixel_x(pixel_x), .pixel_y(pixel_y),
        .graph_on(graph_on), .graph_red(graph_red),
        .graph_green(graph_green), .graph_blue(graph_blue)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;
    int req_cnt = 0, acc_cnt = 0;

    // Pre-edge values at posedge reflect the handshake/pulse of the ending cycle.
    always @(posedge clk) begin
        if (wi.frame_req) req_cnt++;
        if (wi.wr_valid && wi.wr_ready) acc_cnt++;
    end

    typedef struct {
        logic [9:0]  x;
        logic [9:0]  y;
        logic        von;
        logic [12:0] exp;  // {graph_on, r, g, b}
    } vec_t;

    vec_t tab[16];

    function automatic vec_t mk(input int x, input int y, input bit von, input bit on, input logic [11:0] rgb);
        vec_t v;
        v.x = 10'(x); v.y = 10'(y); v.von = von; v.exp = {on, rgb};
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One pixel every 4 clk; returns once the pixel's outputs are stable.
    task automatic pix(input int x, input int y, input bit von);
        @(negedge clk);
        pixel_x = 10'(x); pixel_y = 10'(y); video_on = von; p_tick = 1'b1;
        @(negedge clk);
        p_tick = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic chk_pix(input string name, input logic [12:0] exp);
        chk(name, {19'd0, graph_on, graph_red, graph_green, graph_blue}, {19'd0, exp});
    endtask

    task automatic wr_entry(input int col, input int h, input logic [11:0] c, input bit fd);
        int n;
        n = 0;
        @(negedge clk);
        wi.wr_valid = 1'b1; wi.wr_col = 8'(col); wi.wr_height = 9'(h);
        wi.wr_color = c; wi.frame_done = fd;
        while (!wi.wr_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("wr_handshake", wi.wr_ready, 1);
        @(negedge clk);
        wi.wr_valid = 1'b0; wi.frame_done = 1'b0;
    endtask

    task automatic pulse_done();
        @(negedge clk);
        wi.frame_done = 1'b1;
        @(negedge clk);
        wi.frame_done = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int acc0;
        wi.wr_valid = 0; wi.wr_col = '0; wi.wr_height = '0; wi.wr_color = '0; wi.frame_done = 0;

        repeat (3) @(negedge clk);
        chk("rst_wr_ready", wi.wr_ready, 0);
        chk("rst_graph_on", graph_on, 0);
        chk("rst_frame_req", wi.frame_req, 0);
        chk("rst_wr_err", wi.wr_err, 0);

        RST = 1'b1;
        #1 chk("release_ready_held", wi.wr_ready, 0);
        @(negedge clk);
        chk("release_ready_up", wi.wr_ready, 1);

        // Front bank not yet valid: nothing drawn anywhere.
        pix(40, 200, 1);  chk_pix("pre_swap_a", 13'h0);
        pix(0, 0, 1);     chk_pix("pre_swap_b", 13'h0);
        pix(639, 479, 1); chk_pix("pre_swap_c", 13'h0);

        wr_entry(0,   511, 12'hFFF, 0);
        wr_entry(10,  100, 12'hF00, 0);
        wr_entry(20,  0,   12'hFFF, 0);
        wr_entry(30,  511, 12'h00F, 0);
        wr_entry(40,  511, 12'hA0A, 0);
        wr_entry(40,  0,   12'hA0A, 0);
        wr_entry(200, 511, 12'hFFF, 0);
        chk("wr_err_set", wi.wr_err, 1);
        wr_entry(5,   100, 12'h0F0, 1);

        chk("wait_ready_low", wi.wr_ready, 0);
        chk("no_req_yet", req_cnt, 0);
        pix(40, 200, 1); chk_pix("not_visible_before_swap", 13'h0);
        pix(0, 480, 0);
        chk("req_once", req_cnt, 1);
        chk("fill_after_swap", wi.wr_ready, 1);

        tab[0]  = mk(40, 190, 1, 1, 12'hF00);
        tab[1]  = mk(43, 289, 1, 1, 12'hF00);
        tab[2]  = mk(41, 250, 1, 1, 12'hF00);
        tab[3]  = mk(40, 189, 1, 0, 12'h000);
        tab[4]  = mk(42, 290, 1, 0, 12'h000);
        tab[5]  = mk(40, 250, 0, 0, 12'h000);
        tab[6]  = mk(80, 240, 1, 0, 12'h000);
        tab[7]  = mk(120, 0, 1, 1, 12'h00F);
        tab[8]  = mk(123, 479, 1, 1, 12'h00F);
        tab[9]  = mk(120, 480, 1, 0, 12'h000);
        tab[10] = mk(160, 100, 1, 0, 12'h000);
        tab[11] = mk(20, 190, 1, 1, 12'h0F0);
        tab[12] = mk(23, 289, 1, 1, 12'h0F0);
        tab[13] = mk(21, 290, 1, 0, 12'h000);
        tab[14] = mk(640, 240, 1, 0, 12'h000);
        tab[15] = mk(800, 240, 1, 0, 12'h000);
        for (int i = 0; i < 16; i++) begin
            pix(tab[i].x, tab[i].y, tab[i].von);
            n_cmp++;
            if ({graph_on, graph_red, graph_green, graph_blue} !== tab[i].exp) begin
                n_bad++;
                $display("FAIL pix_vec[%0d] x=%0d y=%0d: got %h expected %h", i, tab[i].x, tab[i].y,
                         {graph_on, graph_red, graph_green, graph_blue}, tab[i].exp);
            end
        end

        // Late frame_done: after this blank's swap point, so it waits a full frame.
        wr_entry(10, 0,   12'hFFF, 0);
        wr_entry(12, 511, 12'h5A5, 0);
        pix(0, 480, 0);
        chk("fill_ignores_swap_pt", req_cnt, 1);
        pix(0, 500, 0);
        pulse_done();
        chk("late_done_ready_low", wi.wr_ready, 0);
        @(negedge clk);
        wi.wr_valid = 1'b1; wi.wr_col = 8'd11; wi.wr_height = 9'd100; wi.wr_color = 12'hF0F;
        acc0 = acc_cnt;
        pix(0, 510, 0);
        pix(0, 0, 1);
        pix(40, 200, 1); chk_pix("old_front_kept", 13'h1F00);
        chk("late_wait_ready_low", wi.wr_ready, 0);
        chk("no_accept_in_wait", acc_cnt, acc0);
        chk("late_no_req", req_cnt, 1);
        pix(0, 480, 0);
        wi.wr_valid = 1'b0;
        chk("late_req", req_cnt, 2);
        chk("accept_after_swap", acc_cnt, acc0 + 1);
        pix(40, 200, 1); chk_pix("new_front_col10", 13'h0);
        pix(48, 10, 1);  chk_pix("new_front_col12_top", 13'h15A5);
        pix(51, 479, 1); chk_pix("new_front_col12_bot", 13'h15A5);
        chk("wr_err_sticky", wi.wr_err, 1);

        // Reset in WAIT_SWAP.
        pulse_done();
        chk("pre_rst_wait", wi.wr_ready, 0);
        pix(48, 10, 1); chk_pix("pre_rst_on", 13'h15A5);
        @(negedge clk);
        RST = 1'b0;
        #1;
        chk_pix("rst_mid_graph", 13'h0);
        chk("rst_mid_ready", wi.wr_ready, 0);
        chk("rst_mid_err", wi.wr_err, 0);
        @(negedge clk);
        RST = 1'b1;
        @(negedge clk);
        chk("rst_mid_fill", wi.wr_ready, 1);
        pix(48, 10, 1); chk_pix("rst_front_invalid", 13'h0);
        chk("rst_no_req", req_cnt, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/wall_column_buffer.md
# wall_column_buffer

Double-buffered wall-slice store between the raycaster and the pixel pipeline. The raycaster writes one {height, colour} entry per screen column into the back bank through a valid/ready handshake. The pixel side reads the front bank at `display` timing and produces `graph_on` and `graph_red/green/blue` for the game's colour mux. Banks swap only at the start of vertical blank, so a frame is never torn.

## Interface
- `H_RES`, 640: visible width in pixels.
- `V_RES`, 480: visible height in pixels.
- `NUM_COLS`, 160: raycast columns; `H_RES >> COL_SHIFT`.
- `COL_SHIFT`, 2: pixel_x to column shift (4 px per column).
- `clk  in  1`: system clock, 100 MHz.
- `RST  in  1`: reset, asynchronous, active-low; everything below returns to reset values immediately.
- `wr_valid  in  1`: raycaster entry valid.
- `wr_ready  out  1`: entry accepted this cycle when both high; reset 0.
- `wr_col  in  8`: target column.
- `wr_height  in  9`: wall height in pixels.
- `wr_color  in  12`: {r,g,b} 4:4:4 wall colour.
- `frame_done  in  1`: 1-cycle pulse; the back bank is complete.
- `frame_req  out  1`: 1-cycle pulse after a swap; the raycaster starts the next frame; reset 0.
- `wr_err  out  1`: sticky; set when an accepted write has `wr_col >= NUM_COLS`; reset 0.
- `p_tick  in  1`: pixel enable from `display`; 1 of every 4 clk.
- `video_on  in  1`: from `display`.
- `pixel_x, pixel_y  in  10`: from `display`.
- `graph_on  out  1`: wall pixel present; reset 0.
- `graph_red, graph_green, graph_blue  out  4`: wall colour; reset 0.

## Operation
- Storage: 2 × `NUM_COLS` entries, 21 bits each; `bank_sel` selects the front bank. Contents are not reset.
- `front_valid` is cleared by reset and set on the first swap. While it is 0, `graph_on` and the colour outputs are 0.
- Write FSM states:
  - FILL: `wr_ready`=1. Handshake writes `back[wr_col]`. `frame_done` moves to WAIT_SWAP.
  - WAIT_SWAP: `wr_ready`=0. On the swap point, move to SWAP.
  - SWAP: one cycle. Toggle `bank_sel`, set `front_valid`, pulse `frame_req`, move to FILL.
- Reset state is FILL, but `wr_ready` is held 0 for the first cycle after RST deasserts.
- Swap point: the `p_tick` cycle with `pixel_y == V_RES` and `pixel_x == 0`.
  - If `frame_done` arrives after that point within the same blank, wait one full frame.
- `frame_done` in the same cycle as an accepted write: the write lands in the back bank first, then the FSM moves to WAIT_SWAP.
- `frame_done` in WAIT_SWAP or SWAP is ignored.
- Writes with `wr_col >= NUM_COLS` complete the handshake and are discarded; they set `wr_err`.
- Repeated writes to the same column: last one wins.
- Pixel path:
  - `col = pixel_x >> COL_SHIFT`; read `front[col]`.
  - `half = height >> 1`.
  - `top = V_RES/2 - half`, saturating at 0; `bot = V_RES/2 + half`, clamped to `V_RES`.
  - Wall when `top <= pixel_y < bot`. Height 0 draws nothing; height ≥ `V_RES` draws the full column.
  - `video_on` = 0 or `col >= NUM_COLS` forces `graph_on` and the colour outputs to 0.

## Timing
- Pixel path is 2 stages: RAM read registered on `p_tick`, then compare and output register.
  - Outputs for pixel N are valid from clk+2 after `p_tick` N until clk+2 after `p_tick` N+1.
  - Requires `p_tick` spacing ≥ 3 clk.
- Write to `back[]`: 1 clk after the handshake. Never visible in front before the swap.
- `frame_done` to `frame_req`: latency is bounded by the swap point plus 1 clk (SWAP state).
- The front bank is read-only between swaps; the same-cycle bank read/write hazard cannot occur.

## Structure
- Package `raycast_pkg`:
  - `H_RES`, `V_RES`, `NUM_COLS`, `COL_SHIFT`.
  - Height width (9) and colour width (12).
  - `wcb_state_t` enum {FILL, WAIT_SWAP, SWAP}.
- Sub-module `column_ram`: simple dual-port, 1 write / 1 synchronous read, depth `2*NUM_COLS`, `bank_sel` as address MSB; infers BRAM/LUTRAM.

## Test plan
- Reset held, then released:
  - During reset: `wr_ready`=0, `graph_on`=0, `frame_req`=0, `wr_err`=0.
  - One cycle after release: `wr_ready`=1.
  - Before any swap: `graph_on` stays 0 for a whole frame.
- Write col 10 height 100 colour 12'hF00; `frame_done`; run to the swap point:
  - `frame_req` pulses once.
  - Next frame: pixel_x 40–43, pixel_y 190–289 give `graph_on`=1 and red=F.
  - y=189 and y=290 give 0.
- Height 0 gives no wall in that column. Height 511 gives a wall on y=0..479.
- `frame_done` while pixel_y=500 (past the swap point): the swap occurs at the next frame's y=480. `wr_ready` stays 0 meanwhile; the write is not accepted until after the swap.
- Write to col 200: the handshake completes, `wr_err`=1 sticky, no entry is modified.
- Simultaneous `wr_valid` (col 5) and `frame_done`: col 5 is displayed after the swap.
- RST asserted mid-WAIT_SWAP: state returns to FILL, `front_valid`=0, `graph_on`=0 immediately.
